// File: rtl/icap_pr_loader.sv
// ICAPE3 partial-reconfiguration loader: streams a word-counted bitstream into the ICAP
// with legal CSIB/RDWRB framing, then waits for PRDONE/PRERROR with a bounded timeout.
module icap_pr_loader #(
  parameter int BITSWAP        = 1,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] word_count,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        ICAP_AVAIL,
  input  logic        ICAP_PRDONE,
  input  logic        ICAP_PRERROR,
  output logic        ICAP_CSIB,
  output logic        ICAP_RDWRB,
  output logic [31:0] ICAP_I,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [31:0] words_written
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PRERROR = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ABORT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_WAIT_DONE,
    S_TEARDOWN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   remaining_reg, remaining_next;
  logic [31:0]   words_written_reg, words_written_next;
  logic          csib_reg, csib_next;
  logic          rdwrb_reg, rdwrb_next;
  logic [31:0]   icap_i_reg, icap_i_next;
  logic [1:0]    err_code_reg, err_code_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  logic [31:0]   swapped;
  logic          handshake;

  // ICAP expects the bits of each byte reversed relative to the usual bitstream file order
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_swap
      if (BITSWAP != 0) begin : g_rev
        assign swapped[gi] = s_data[(gi / 8) * 8 + 7 - (gi % 8)];
      end else begin : g_pass
        assign swapped[gi] = s_data[gi];
      end
    end
  endgenerate

  // Abort and PRERROR must drop ready in the same cycle so no word is consumed after them
  assign s_ready   = (state_reg == S_WRITE) && ICAP_AVAIL && (remaining_reg != 32'd0)
                     && !abort && !ICAP_PRERROR;
  assign handshake = s_valid && s_ready;

  always_comb begin
    state_next         = state_reg;
    remaining_next     = remaining_reg;
    words_written_next = words_written_reg;
    csib_next          = csib_reg;
    rdwrb_next         = rdwrb_reg;
    icap_i_next        = icap_i_reg;
    err_code_next      = err_code_reg;
    timeout_next       = timeout_reg;

    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          words_written_next = 32'd0;
          err_code_next      = ERR_NONE;
          timeout_next       = '0;
          if (word_count == 32'd0) begin
            state_next = S_DONE;
          end else begin
            remaining_next = word_count;
            state_next     = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        if (abort) begin
          err_code_next = ERR_ABORT;
          state_next    = S_TEARDOWN;
        end else begin
          rdwrb_next = 1'b0;
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        csib_next = 1'b1;
        if (abort) begin
          err_code_next = ERR_ABORT;
          state_next    = S_TEARDOWN;
        end else if (ICAP_PRERROR) begin
          err_code_next = ERR_PRERROR;
          state_next    = S_TEARDOWN;
        end else if (handshake) begin
          icap_i_next        = swapped;
          csib_next          = 1'b0;
          remaining_next     = remaining_reg - 32'd1;
          words_written_next = words_written_reg + 32'd1;
          if (remaining_reg == 32'd1) begin
            timeout_next = '0;
            state_next   = S_WAIT_DONE;
          end
        end
      end

      S_WAIT_DONE: begin
        csib_next    = 1'b1;
        timeout_next = timeout_reg + TO_ONE;
        if (abort) begin
          err_code_next = ERR_ABORT;
          state_next    = S_TEARDOWN;
        end else if (ICAP_PRERROR) begin
          err_code_next = ERR_PRERROR;
          state_next    = S_TEARDOWN;
        end else if (ICAP_PRDONE) begin
          state_next = S_TEARDOWN;
        end else if (timeout_reg == TO_LAST) begin
          err_code_next = ERR_TIMEOUT;
          state_next    = S_TEARDOWN;
        end
      end

      S_TEARDOWN: begin
        // CSIB was already high for the whole previous cycle, so RDWRB may rise here
        csib_next  = 1'b1;
        rdwrb_next = 1'b1;
        state_next = (err_code_reg == ERR_NONE) ? S_DONE : S_ERROR;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg         <= S_IDLE;
      remaining_reg     <= 32'd0;
      words_written_reg <= 32'd0;
      csib_reg          <= 1'b1;
      rdwrb_reg         <= 1'b1;
      icap_i_reg        <= 32'd0;
      err_code_reg      <= ERR_NONE;
      timeout_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      remaining_reg     <= remaining_next;
      words_written_reg <= words_written_next;
      csib_reg          <= csib_next;
      rdwrb_reg         <= rdwrb_next;
      icap_i_reg        <= icap_i_next;
      err_code_reg      <= err_code_next;
      timeout_reg       <= timeout_next;
    end
  end

  assign ICAP_CSIB     = csib_reg;
  assign ICAP_RDWRB    = rdwrb_reg;
  assign ICAP_I        = icap_i_reg;
  assign busy          = (state_reg == S_SETUP) || (state_reg == S_WRITE) ||
                         (state_reg == S_WAIT_DONE) || (state_reg == S_TEARDOWN);
  assign done          = (state_reg == S_DONE);
  assign error         = (state_reg == S_ERROR);
  assign err_code      = error ? err_code_reg : ERR_NONE;
  assign words_written = words_written_reg;

endmodule

// File: tb/tb_icap_pr_loader.sv
// Scoreboard bench for icap_pr_loader: accepted words queue their expected ICAP_I value,
// the negedge monitor pops one per CSIB-low cycle and checks framing around RDWRB edges.
module tb_icap_pr_loader;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, abort;
  logic [31:0] word_count;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic        ICAP_AVAIL, ICAP_PRDONE, ICAP_PRERROR;
  logic        ICAP_CSIB, ICAP_RDWRB;
  logic [31:0] ICAP_I;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [31:0] words_written;

  icap_pr_loader #(.BITSWAP(1), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .word_count(word_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ICAP_AVAIL(ICAP_AVAIL), .ICAP_PRDONE(ICAP_PRDONE), .ICAP_PRERROR(ICAP_PRERROR),
    .ICAP_CSIB(ICAP_CSIB), .ICAP_RDWRB(ICAP_RDWRB), .ICAP_I(ICAP_I),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .words_written(words_written)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];
  logic [31:0] src[16];
  logic [31:0] src_exp[16];
  int          src_n = 0, src_idx = 0, hs_cnt = 0, csib_low_cnt = 0;
  logic        sr_samp;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] x);
    logic [31:0] y;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        y[8*k+i] = x[8*k+7-i];
    return y;
  endfunction

  // Monitor: one line per word that reaches the ICAP
  initial begin
    logic        prev_csib, prev_rdwrb;
    logic [31:0] e;
    prev_csib  = 1'b1;
    prev_rdwrb = 1'b1;
    forever begin
      @(negedge CLK);
      if (!RST && (ICAP_RDWRB !== prev_rdwrb)) begin
        check("rdwrb_edge_pre_csib", prev_csib, 1);
        check("rdwrb_edge_post_csib", ICAP_CSIB, 1);
      end
      if (ICAP_CSIB === 1'b0) begin
        csib_low_cnt++;
        e = (sb.size() != 0) ? sb.pop_front() : ~ICAP_I;
        check("icap_i", ICAP_I, e);
        check("rdwrb_during_write", ICAP_RDWRB, 0);
        $display("word %0d icap_i=0x%08h expected=0x%08h", csib_low_cnt, ICAP_I, e);
      end
      prev_csib  = ICAP_CSIB;
      prev_rdwrb = ICAP_RDWRB;
    end
  end

  task automatic drive_src();
    if (src_idx < src_n) begin
      s_valid = 1'b1;
      s_data  = src[src_idx];
    end else begin
      s_valid = 1'b0;
      s_data  = 32'd0;
    end
  endtask

  // Called at negedge+1; samples the handshake just before the posedge
  task automatic tick();
    #3;
    sr_samp = s_ready;
    if (s_valid && s_ready) begin
      sb.push_back(src_exp[src_idx]);
      src_idx++;
      hs_cnt++;
    end
    @(negedge CLK);
    #1;
    drive_src();
  endtask

  task automatic prep(input int n);
    src_n   = n;
    src_idx = 0;
    hs_cnt  = 0;
    for (int i = 0; i < n; i++) begin
      src[i]     = $urandom;
      src_exp[i] = swap(src[i]);
    end
    drive_src();
  endtask

  task automatic start_load(input logic [31:0] wc);
    word_count = wc;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic feed(input int lo_at, input int lo_len, input int err_at, input int exp_hs);
    int guard, lo_left;
    bit lo_done, stop;
    guard = 0; lo_left = 0; lo_done = 0; stop = 0;
    while (!stop && src_idx < src_n && guard < 200) begin
      guard++;
      if (err_at >= 0 && hs_cnt == err_at) begin
        ICAP_PRERROR = 1'b1;
        tick();
        ICAP_PRERROR = 1'b0;
        check("prerr_s_ready", sr_samp, 0);
        check("prerr_csib", ICAP_CSIB, 1);
        src_n = src_idx;
        drive_src();
        stop = 1;
      end else begin
        if (!lo_done && lo_at >= 0 && hs_cnt == lo_at) begin
          lo_left = lo_len;
          lo_done = 1;
        end
        ICAP_AVAIL = (lo_left == 0);
        tick();
        if (lo_left > 0) begin
          check("avail_low_s_ready", sr_samp, 0);
          check("avail_low_csib", ICAP_CSIB, 1);
          lo_left--;
        end
      end
    end
    ICAP_AVAIL = 1'b1;
    check("feed_handshakes", hs_cnt, exp_hs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, low;
    RST = 1'b1; start = 1'b0; abort = 1'b0; word_count = 32'd0;
    s_data = 32'd0; s_valid = 1'b0;
    ICAP_AVAIL = 1'b1; ICAP_PRDONE = 1'b0; ICAP_PRERROR = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_csib", ICAP_CSIB, 1);
    check("rst_rdwrb", ICAP_RDWRB, 1);
    check("rst_icap_i", ICAP_I, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_err_code", err_code, 0);
    check("rst_words", words_written, 0);
    RST = 1'b0;

    // Known-answer load of four words
    prep(4);
    src[0] = 32'h000000BB; src_exp[0] = 32'h000000DD;
    src[1] = 32'h11220044; src_exp[1] = 32'h88440022;
    src[2] = 32'hAA995566; src_exp[2] = 32'h5599AA66;
    src[3] = 32'h20000000; src_exp[3] = 32'h04000000;
    drive_src();
    low = csib_low_cnt;
    start_load(4);
    check("t1_setup_busy", busy, 1);
    check("t1_setup_rdwrb", ICAP_RDWRB, 1);
    tick();
    check("t1_pre_write_rdwrb", ICAP_RDWRB, 0);
    check("t1_pre_write_csib", ICAP_CSIB, 1);
    feed(-1, 0, -1, 4);
    check("t1_last_word_csib", ICAP_CSIB, 0);
    check("t1_csib_low_count", csib_low_cnt - low, 4);
    ICAP_PRDONE = 1'b1;
    tick();
    ICAP_PRDONE = 1'b0;
    check("t1_teardown_csib", ICAP_CSIB, 1);
    check("t1_teardown_rdwrb", ICAP_RDWRB, 0);
    check("t1_teardown_busy", busy, 1);
    tick();
    check("t1_rdwrb_back", ICAP_RDWRB, 1);
    check("t1_done", done, 1);
    check("t1_error", error, 0);
    check("t1_words", words_written, 4);
    check("t1_sb_empty", sb.size(), 0);

    // AVAIL drops for three cycles mid-stream
    prep(8);
    start_load(8);
    feed(3, 3, -1, 8);
    ICAP_PRDONE = 1'b1;
    tick();
    ICAP_PRDONE = 1'b0;
    tick();
    check("t2_done", done, 1);
    check("t2_words", words_written, 8);
    check("t2_sb_empty", sb.size(), 0);

    // PRERROR after word 5 of 10
    prep(10);
    start_load(10);
    feed(-1, 0, 5, 5);
    tick();
    check("t3_error", error, 1);
    check("t3_done", done, 0);
    check("t3_err_code", err_code, 2'b01);
    check("t3_words", words_written, 5);
    check("t3_sb_empty", sb.size(), 0);

    // No PRDONE: timeout after TO cycles in WAIT_DONE plus teardown
    prep(2);
    start_load(2);
    feed(-1, 0, -1, 2);
    t = 0;
    while (!error && t < 100) begin
      tick();
      t++;
    end
    check("t4_timeout_cycles", t, TO + 1);
    check("t4_err_code", err_code, 2'b10);
    check("t4_words", words_written, 2);

    // abort beats PRDONE, then a zero-length load
    prep(3);
    start_load(3);
    feed(-1, 0, -1, 3);
    abort = 1'b1;
    ICAP_PRDONE = 1'b1;
    tick();
    abort = 1'b0;
    ICAP_PRDONE = 1'b0;
    check("t5_teardown_csib", ICAP_CSIB, 1);
    tick();
    check("t5_error", error, 1);
    check("t5_done", done, 0);
    check("t5_err_code", err_code, 2'b11);
    low = csib_low_cnt;
    start_load(0);
    check("t5_zero_done", done, 1);
    check("t5_zero_busy", busy, 0);
    check("t5_zero_err_code", err_code, 0);
    check("t5_zero_words", words_written, 0);
    check("t5_zero_no_csib", csib_low_cnt - low, 0);

    // Reset mid-write, then start while busy must be ignored
    prep(6);
    start_load(6);
    tick();
    tick();
    tick();
    check("t6_csib_low_before_rst", ICAP_CSIB, 0);
    RST = 1'b1;
    tick();
    check("t6_rst_csib", ICAP_CSIB, 1);
    check("t6_rst_rdwrb", ICAP_RDWRB, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_words", words_written, 0);
    RST = 1'b0;
    sb.delete();
    src_n = 0;
    drive_src();
    prep(4);
    start_load(4);
    word_count = 32'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(-1, 0, -1, 4);
    ICAP_PRDONE = 1'b1;
    tick();
    ICAP_PRDONE = 1'b0;
    tick();
    check("t6_done", done, 1);
    check("t6_words", words_written, 4);
    check("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icap_pr_loader.md
Name: icap_pr_loader

Overview:
- Sequences the ICAPE3 primitive for partial reconfiguration (DFX).
- Accepts a partial bitstream as a 32-bit valid/ready word stream and optionally bit-swaps each byte to ICAP ordering.
- Drives CSIB/RDWRB/I with legal write framing, honours AVAIL back-pressure, then waits for PRDONE/PRERROR with a timeout.
- Sits between the DMA/FIFO stream path and the ICAP wrapper; reports status to the PS control registers.

Parameters:
- BITSWAP, 1, 1 = reverse bit order within each byte of s_data before driving ICAP_I; 0 = pass through.
- TIMEOUT_CYCLES, 1048576, max cycles in WAIT_DONE before a timeout error; width ceil(log2(TIMEOUT_CYCLES+1)).

Ports:
- CLK  in  1  single clock; also the ICAPE3 CLK.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load when IDLE, DONE or ERROR.
- abort  in  1  level; forces ERROR from any busy state.
- word_count  in  32  number of 32-bit words to write; sampled on accepted start.
- s_data  in  32  bitstream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- ICAP_AVAIL  in  1  from ICAPE3 AVAIL.
- ICAP_PRDONE  in  1  from ICAPE3 PRDONE.
- ICAP_PRERROR  in  1  from ICAPE3 PRERROR.
- ICAP_CSIB  out  1  to ICAPE3 CSIB (active low).
- ICAP_RDWRB  out  1  to ICAPE3 RDWRB (0 = write).
- ICAP_I  out  32  to ICAPE3 I.
- busy  out  1  high in SETUP, WRITE, WAIT_DONE, TEARDOWN.
- done  out  1  level; high in DONE.
- error  out  1  level; high in ERROR.
- err_code  out  2  01 PRERROR, 10 timeout, 11 abort; 00 otherwise.
- words_written  out  32  count of words driven with CSIB low in the current or last load.

Behaviour:
- Reset values:
  - ICAP_CSIB = 1, ICAP_RDWRB = 1, ICAP_I = 0.
  - s_ready = 0, busy = 0, done = 0, error = 0, err_code = 00, words_written = 0.
  - State = IDLE.
- ICAP_CSIB, ICAP_RDWRB and ICAP_I are registered. s_ready is combinational: (state == WRITE) && ICAP_AVAIL && remaining != 0.
- RDWRB never changes in a cycle where CSIB is low on the outgoing register. CSIB is high for at least one cycle on each side of any RDWRB edge.
- States:
  - IDLE / DONE / ERROR: accept start.
    - word_count == 0 -> DONE next cycle; no ICAP activity.
    - Otherwise: latch remaining = word_count, clear words_written / done / error / err_code, go to SETUP.
    - start while busy is ignored.
  - SETUP (1 cycle): ICAP_RDWRB <= 0, CSIB stays 1 -> WRITE.
  - WRITE:
    - On handshake: ICAP_I <= swap(s_data), ICAP_CSIB <= 0, remaining decrements, words_written increments.
    - No handshake (s_valid low or AVAIL low): ICAP_CSIB <= 1 and ICAP_I holds.
    - On the handshake that makes remaining 0 -> WAIT_DONE. The final word is on the ICAP in the first WAIT_DONE cycle; CSIB <= 1 on the following edge.
  - WAIT_DONE:
    - CSIB = 1, RDWRB = 0; timeout counter increments.
    - ICAP_PRDONE -> TEARDOWN (success).
    - ICAP_PRERROR -> TEARDOWN (err 01).
    - Counter reaches TIMEOUT_CYCLES -> TEARDOWN (err 10).
  - TEARDOWN (1 cycle): RDWRB <= 1 -> DONE if success, else ERROR with the latched err_code.
- ICAP_PRERROR during WRITE: stop accepting (s_ready low the same cycle), CSIB <= 1, -> TEARDOWN, err 01.
- abort in SETUP/WRITE/WAIT_DONE:
  - Same cycle: s_ready = 0.
  - Next edge: CSIB <= 1.
  - Then TEARDOWN -> ERROR, err 11.
  - abort wins over PRDONE and PRERROR in the same cycle.
  - abort in IDLE/DONE/ERROR has no effect.
- Same-cycle priority in WAIT_DONE: abort > PRERROR > PRDONE > timeout.
- swap(x) with BITSWAP=1: for each byte k, out[8k+i] = x[8k+7-i]. Byte order is unchanged.
- RST mid-load: all outputs return to reset values on the next edge (CSIB=1, RDWRB=1); no teardown sequence.
- Counters saturate never; words_written ≤ word_count by construction.

Test Plan:
- Load of 4 words 0x000000BB, 0x11220044, 0xAA995566, 0x20000000 with s_valid held high, AVAIL=1, BITSWAP=1 -> ICAP_I shows 0x000000DD, 0x88440022, 0x5599AA66, 0x04000000 on 4 consecutive CSIB-low cycles. RDWRB=0 one cycle before the first CSIB low and returns to 1 one cycle after TEARDOWN. PRDONE pulse -> done=1, words_written=4.
- AVAIL low for 3 cycles mid-stream of 8 words -> s_ready low and CSIB high during those cycles, no word lost or duplicated, words_written=8.
- PRERROR asserted after word 5 of 10 -> CSIB high next edge, s_ready=0, error=1, err_code=01, words_written=5.
- TIMEOUT_CYCLES=16, no PRDONE after the last word -> error=1, err_code=10 exactly 16 cycles after entering WAIT_DONE, plus 1 TEARDOWN cycle.
- abort and PRDONE in the same WAIT_DONE cycle -> err_code=11, done=0. Then start with word_count=0 -> done=1 after 1 cycle, CSIB never low.
- RST asserted while CSIB is low in WRITE -> next cycle CSIB=1, RDWRB=1, busy=0. start during busy is ignored and the word_count change is not latched.
